// File: rtl/ram_configurable_pkg.sv
// Shared definitions for the configurable RAM primitive and its wrappers:
// reset-mode selectors, default partition count and the init FSM states.
package ram_configurable_pkg;

   localparam int STRUCT_PARTS     = 4;
   localparam int STRUCT_PARTS_LOG = 2;

   typedef enum logic {
      RAM_RESET_ZERO = 1'b0,
      RAM_RESET_SEQ  = 1'b1
   } ramResetMode_e;

   typedef enum logic {
      INIT  = 1'b0,
      READY = 1'b1
   } ramInitState_e;

   // Value written into an entry during self-initialisation; the caller truncates to WIDTH.
   function automatic int unsigned ramInitValue(ramResetMode_e mode, int unsigned seqStart,
                                                int unsigned addr);
      return (mode == RAM_RESET_SEQ) ? seqStart + addr : 32'd0;
   endfunction

endpackage

// File: rtl/ram_partition.sv
// One partition of ram_configurable: a ROWS-entry flop array with combinational
// read ports, prioritised write ports and a dedicated init write port.
module ram_partition #(
   parameter int ROWS         = 32,
   parameter int ROW_IDX      = 5,
   parameter int WIDTH        = 8,
   parameter int NUM_WR_PORTS = 8,
   parameter int NUM_RD_PORTS = 16
) (
   input  logic                                    clk,
   input  logic [NUM_RD_PORTS-1:0][ROW_IDX-1:0]    rowRd_i,
   output logic [NUM_RD_PORTS-1:0][WIDTH-1:0]      data_o,
   input  logic [NUM_WR_PORTS-1:0][ROW_IDX-1:0]    rowWr_i,
   input  logic [NUM_WR_PORTS-1:0][WIDTH-1:0]      dataWr_i,
   input  logic [NUM_WR_PORTS-1:0]                 wrEn_i,
   input  logic                                    initEn_i,
   input  logic [ROW_IDX-1:0]                      initRow_i,
   input  logic [WIDTH-1:0]                        initData_i
);

   logic [WIDTH-1:0] mem [ROWS];

   always_ff @(posedge clk) begin
      if (initEn_i) begin
         mem[initRow_i] <= initData_i;
      end
      // Ascending port order: on a shared row the highest-numbered port's write lands last.
      for (int w = 0; w < NUM_WR_PORTS; w++) begin
         if (wrEn_i[w]) begin
            mem[rowWr_i[w]] <= dataWr_i[w];
         end
      end
   end

   genvar gi;
   generate
      for (gi = 0; gi < NUM_RD_PORTS; gi++) begin : gRead
         assign data_o[gi] = mem[rowRd_i[gi]];
      end
   endgenerate

endmodule

// File: rtl/ram_configurable.sv
// Multi-port partitioned register-file RAM with port/partition gating and self-initialisation.
// Optional build macro RAM_CONFIGURABLE_WR_CONFLICT_CHECK_EN adds a simulation write-conflict check.
module ram_configurable
   import ram_configurable_pkg::*;
#(
   parameter int            DEPTH           = 128,
   parameter int            INDEX           = 7,
   parameter int            WIDTH           = 8,
   parameter int            NUM_WR_PORTS    = 8,
   parameter int            NUM_RD_PORTS    = 16,
   parameter int            WR_PORTS_LOG    = 3,
   parameter int            USE_RAM_2READ   = 0,
   parameter int            SHARED_DECODE   = 0,
   parameter int            USE_PARTITIONED = 1,
   parameter int            USE_FLIP_FLOP   = 0,
   parameter int            NUM_PARTS       = STRUCT_PARTS,
   parameter int            NUM_PARTS_LOG   = STRUCT_PARTS_LOG,
   parameter ramResetMode_e RESET_VAL       = RAM_RESET_ZERO,
   parameter int            SEQ_START       = 34
) (
   input  logic                                  clk,
   input  logic                                  reset,
   input  logic [NUM_WR_PORTS-1:0]               writePortGated_i,
   input  logic [NUM_RD_PORTS-1:0]               readPortGated_i,
   input  logic [NUM_PARTS-1:0]                  partitionGated_i,
   input  logic [NUM_RD_PORTS-1:0][INDEX-1:0]    addr_i,
   output logic [NUM_RD_PORTS-1:0][WIDTH-1:0]    data_o,
   input  logic [NUM_WR_PORTS-1:0][INDEX-1:0]    addrWr_i,
   input  logic [NUM_WR_PORTS-1:0][WIDTH-1:0]    dataWr_i,
   input  logic [NUM_WR_PORTS-1:0]               wrEn_i,
   output logic                                  ramReady_o
);

   localparam int ROWS    = DEPTH / NUM_PARTS;
   localparam int ROW_IDX = INDEX - NUM_PARTS_LOG;

   // The style selectors only have to be legal; an inconsistent geometry never reports ready.
   localparam bit CFG_OK = ((1 << WR_PORTS_LOG) >= NUM_WR_PORTS) &&
                           (DEPTH == (1 << INDEX)) &&
                           (NUM_PARTS == (1 << NUM_PARTS_LOG)) &&
                           (USE_RAM_2READ < 2) && (SHARED_DECODE < 2) &&
                           (USE_PARTITIONED < 2) && (USE_FLIP_FLOP < 2);

   ramInitState_e              stateReg, stateNext;
   logic [ROW_IDX-1:0]         rowCntReg, rowCntNext;
   logic                       readyReg, readyNext;
   logic                       initEn;

   logic [NUM_WR_PORTS-1:0][NUM_PARTS_LOG-1:0]     wrPart;
   logic [NUM_WR_PORTS-1:0][ROW_IDX-1:0]           wrRow;
   logic [NUM_WR_PORTS-1:0]                        wrEff;
   logic [NUM_PARTS-1:0][NUM_WR_PORTS-1:0]         partWrEn;
   logic [NUM_RD_PORTS-1:0][NUM_PARTS_LOG-1:0]     rdPart;
   logic [NUM_RD_PORTS-1:0][ROW_IDX-1:0]           rdRow;
   logic [NUM_PARTS-1:0][NUM_RD_PORTS-1:0][WIDTH-1:0] partData;
   logic [NUM_PARTS-1:0][WIDTH-1:0]                partInitData;

   always_ff @(posedge clk) begin
      if (reset) begin
         stateReg  <= INIT;
         rowCntReg <= '0;
         readyReg  <= 1'b0;
      end else begin
         stateReg  <= stateNext;
         rowCntReg <= rowCntNext;
         readyReg  <= readyNext;
      end
   end

   // One row per cycle, written into every partition at once.
   always_comb begin
      stateNext  = stateReg;
      rowCntNext = rowCntReg;
      readyNext  = readyReg;
      initEn     = 1'b0;
      case (stateReg)
         INIT: begin
            initEn = 1'b1;
            if (rowCntReg == ROW_IDX'(ROWS - 1)) begin
               stateNext = READY;
               readyNext = 1'b1;
            end else begin
               rowCntNext = rowCntReg + 1'b1;
            end
         end
         READY: begin
            readyNext = 1'b1;
         end
      endcase
   end

   assign ramReady_o = readyReg & CFG_OK;

   genvar gi;
   generate
      for (gi = 0; gi < NUM_WR_PORTS; gi++) begin : gWrDecode
         assign wrPart[gi] = addrWr_i[gi][INDEX-1 -: NUM_PARTS_LOG];
         assign wrRow[gi]  = addrWr_i[gi][ROW_IDX-1:0];
         assign wrEff[gi]  = wrEn_i[gi] & ~writePortGated_i[gi] &
                             ~partitionGated_i[wrPart[gi]] & ramReady_o;
      end

      for (gi = 0; gi < NUM_RD_PORTS; gi++) begin : gRdDecode
         assign rdPart[gi] = addr_i[gi][INDEX-1 -: NUM_PARTS_LOG];
         assign rdRow[gi]  = addr_i[gi][ROW_IDX-1:0];
         assign data_o[gi] = (readPortGated_i[gi] || partitionGated_i[rdPart[gi]]) ?
                             '0 : partData[rdPart[gi]][gi];
      end

      for (gi = 0; gi < NUM_PARTS; gi++) begin : gPart
         assign partInitData[gi] = WIDTH'(ramInitValue(RESET_VAL, SEQ_START,
                                          (gi << ROW_IDX) + 32'(rowCntReg)));

         ram_partition #(
            .ROWS         (ROWS),
            .ROW_IDX      (ROW_IDX),
            .WIDTH        (WIDTH),
            .NUM_WR_PORTS (NUM_WR_PORTS),
            .NUM_RD_PORTS (NUM_RD_PORTS)
         ) uPartition (
            .clk        (clk),
            .rowRd_i    (rdRow),
            .data_o     (partData[gi]),
            .rowWr_i    (wrRow),
            .dataWr_i   (dataWr_i),
            .wrEn_i     (partWrEn[gi]),
            .initEn_i   (initEn),
            .initRow_i  (rowCntReg),
            .initData_i (partInitData[gi])
         );
      end
   endgenerate

   always_comb begin
      partWrEn = '0;
      for (int p = 0; p < NUM_PARTS; p++) begin
         for (int w = 0; w < NUM_WR_PORTS; w++) begin
            partWrEn[p][w] = wrEff[w] && (wrPart[w] == NUM_PARTS_LOG'(p));
         end
      end
   end

`ifdef RAM_CONFIGURABLE_WR_CONFLICT_CHECK_EN
   always_ff @(posedge clk) begin
      for (int i = 0; i < NUM_WR_PORTS; i++) begin
         for (int j = i + 1; j < NUM_WR_PORTS; j++) begin
            if (wrEff[i] && wrEff[j] && (addrWr_i[i] == addrWr_i[j])) begin
               $error("ram_configurable: write ports %0d and %0d both target address %0d",
                      i, j, addrWr_i[i]);
            end
         end
      end
   end
`else
   // Conflicting writes resolve silently by port priority.
`endif

endmodule

// File: tb/tb_ram_configurable.sv
// Self-checking bench for ram_configurable: init timing and values, randomized
// read/write traffic against a golden array, and directed gating/priority sequences.
module tb_ram_configurable;
   import ram_configurable_pkg::*;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic              reset;
   logic [7:0]        writePortGated;
   logic [15:0]       readPortGated;
   logic [3:0]        partitionGated;
   logic [15:0][6:0]  addr;
   logic [15:0][7:0]  dataZ, dataS;
   logic [7:0][6:0]   addrWr;
   logic [7:0][7:0]   dataWr;
   logic [7:0]        wrEn;
   logic              readyZ, readyS;

   int checks = 0;
   int errors = 0;
   logic [7:0] gold [128];

   ram_configurable #(.RESET_VAL(RAM_RESET_ZERO)) dutZ (
      .clk(clk), .reset(reset), .writePortGated_i(writePortGated),
      .readPortGated_i(readPortGated), .partitionGated_i(partitionGated),
      .addr_i(addr), .data_o(dataZ), .addrWr_i(addrWr), .dataWr_i(dataWr),
      .wrEn_i(wrEn), .ramReady_o(readyZ));

   ram_configurable #(.RESET_VAL(RAM_RESET_SEQ), .SEQ_START(34)) dutS (
      .clk(clk), .reset(reset), .writePortGated_i(writePortGated),
      .readPortGated_i(readPortGated), .partitionGated_i(partitionGated),
      .addr_i(addr), .data_o(dataS), .addrWr_i(addrWr), .dataWr_i(dataWr),
      .wrEn_i(wrEn), .ramReady_o(readyS));

   typedef struct {
      logic [6:0] a;
      logic [7:0] expZ;
      logic [7:0] expS;
   } initVec_t;
   initVec_t vecs [7];

   task automatic check(string name, int act, int exp);
      checks++;
      if (act != exp) begin
         errors++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
      end
   endtask

   // Reference read: gated port or gated partition gives 0, else the golden entry.
   function automatic int expRead(int port);
      int a = int'(addr[port]);
      if (readPortGated[port] || partitionGated[a / 32]) return 0;
      return int'(gold[a]);
   endfunction

   task automatic checkReads(string tag);
      for (int r = 0; r < 16; r++) begin
         check($sformatf("%s rd%0d addr 0x%0h", tag, r, addr[r]), int'(dataZ[r]), expRead(r));
      end
   endtask

   task automatic modelCommit();
      for (int w = 0; w < 8; w++) begin
         if (wrEn[w] && !writePortGated[w] && !partitionGated[int'(addrWr[w]) / 32]) begin
            gold[addrWr[w]] = dataWr[w];
         end
      end
   endtask

   // Check reads mid-cycle, apply the model's writes, then advance past the edge.
   task automatic cycle(string tag);
      @(negedge clk);
      checkReads(tag);
      modelCommit();
      @(posedge clk);
      #1;
      $display("[%0t] %s wrEn=%b checks=%0d", $time, tag, wrEn, checks);
   endtask

   initial begin
      repeat (50000) @(posedge clk);
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1, "watchdog expired");
   end

   initial begin
      int n;
      logic [7:0] keep;
      reset = 1'b1;
      writePortGated = '0;
      readPortGated  = '0;
      partitionGated = '0;
      addr   = '0;
      addrWr = '0;
      dataWr = '0;
      wrEn   = '0;
      for (int a = 0; a < 128; a++) gold[a] = 8'h00;

      vecs[0] = '{7'd0,   8'h00, 8'd34};
      vecs[1] = '{7'd5,   8'h00, 8'd39};
      vecs[2] = '{7'd31,  8'h00, 8'd65};
      vecs[3] = '{7'd32,  8'h00, 8'd66};
      vecs[4] = '{7'd64,  8'h00, 8'd98};
      vecs[5] = '{7'd96,  8'h00, 8'd130};
      vecs[6] = '{7'd127, 8'h00, 8'hA1};

      // Reset, then init; a write attempted during INIT must be dropped.
      repeat (5) @(posedge clk);
      #1;
      check("reset readyZ", int'(readyZ), 0);
      check("reset readyS", int'(readyS), 0);
      wrEn[0] = 1'b1; addrWr[0] = 7'd3; dataWr[0] = 8'hEE;
      reset = 1'b0;
      for (int e = 1; e <= 34; e++) begin
         @(posedge clk);
         #1;
         check($sformatf("init ready edge %0d", e), int'(readyZ), (e >= 32) ? 1 : 0);
         check($sformatf("init readyS edge %0d", e), int'(readyS), (e >= 32) ? 1 : 0);
         $display("[%0t] init edge %0d ready=%0d", $time, e, readyZ);
         if (e == 31) wrEn = '0;
      end

      for (int i = 0; i < 7; i++) begin
         addr[0] = vecs[i].a;
         @(negedge clk);
         check($sformatf("initval zero addr %0d", vecs[i].a), int'(dataZ[0]), int'(vecs[i].expZ));
         check($sformatf("initval seq addr %0d", vecs[i].a), int'(dataS[0]), int'(vecs[i].expS));
         $display("[%0t] init vector addr %0d zero=0x%0h seq=0x%0h", $time, vecs[i].a, dataZ[0], dataS[0]);
         @(posedge clk);
         #1;
      end

      for (int b = 0; b < 8; b++) begin
         for (int r = 0; r < 16; r++) addr[r] = 7'(b * 16 + r);
         cycle($sformatf("zero sweep %0d", b));
      end

      // Random traffic, partitions 1..3 gated.
      partitionGated = 4'b1110;
      for (int c = 0; c < 200; c++) begin
         for (int w = 0; w < 8; w++) begin
            wrEn[w]   = 1'($urandom_range(0, 1));
            addrWr[w] = ($urandom_range(0, 3) == 0) ? 7'($urandom_range(0, 127))
                                                     : 7'($urandom_range(0, 31));
            dataWr[w] = 8'($urandom);
         end
         for (int r = 0; r < 16; r++) begin
            addr[r] = ($urandom_range(0, 3) == 0) ? 7'($urandom_range(0, 127))
                                                   : 7'($urandom_range(0, 31));
         end
         cycle($sformatf("rand %0d", c));
      end
      wrEn = '0;
      partitionGated = '0;

      // Ports 2 and 6 collide on 0x10; port 6 must win.
      wrEn[2] = 1'b1; addrWr[2] = 7'h10; dataWr[2] = 8'hAA;
      wrEn[6] = 1'b1; addrWr[6] = 7'h10; dataWr[6] = 8'h55;
      addr[0] = 7'h10;
      cycle("conflict write");
      wrEn = '0;
      check("conflict 0x10", int'(dataZ[0]), 8'h55);

      // Gated write port 3 and gated read port 9.
      wrEn[0] = 1'b1; addrWr[0] = 7'd4; dataWr[0] = 8'h21;
      cycle("set addr4");
      wrEn = '0;
      keep = gold[4];
      writePortGated[3] = 1'b1;
      wrEn[3] = 1'b1; addrWr[3] = 7'd4; dataWr[3] = 8'h7F;
      addr[1] = 7'd4;
      readPortGated[9] = 1'b1;
      addr[9] = 7'h10;
      cycle("gated port write");
      wrEn = '0;
      check("wp3 gated addr4", int'(dataZ[1]), int'(keep));
      check("rp9 gated", int'(dataZ[9]), 0);
      writePortGated = '0;
      readPortGated  = '0;
      #1;
      check("rp9 ungated", int'(dataZ[9]), 8'h55);

      // Partition 2 gating hides and protects its contents.
      wrEn[0] = 1'b1; addrWr[0] = 7'h50; dataWr[0] = 8'h3C;
      addr[2] = 7'h50;
      cycle("write 0x50");
      wrEn = '0;
      partitionGated = 4'b0100;
      wrEn[1] = 1'b1; addrWr[1] = 7'h50; dataWr[1] = 8'h99;
      cycle("gated partition write");
      wrEn = '0;
      check("part2 gated read", int'(dataZ[2]), 0);
      partitionGated = '0;
      #1;
      check("part2 ungated read", int'(dataZ[2]), 8'h3C);
      cycle("ungated readback");

      // Mid-operation reset drops ready and re-initialises the array.
      reset = 1'b1;
      @(posedge clk);
      #1;
      check("mid reset ready", int'(readyZ), 0);
      reset = 1'b0;
      n = 0;
      while (!readyZ && n < 100) begin
         @(posedge clk);
         #1;
         n++;
      end
      check("reinit edges", n, 32);
      $display("[%0t] reinit ready after %0d edges", $time, n);
      for (int a = 0; a < 128; a++) gold[a] = 8'h00;
      for (int r = 0; r < 16; r++) addr[r] = 7'(64 + r);
      addr[0] = 7'h50;
      addr[1] = 7'h10;
      cycle("post reinit read");

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
